// File: rtl/msg_pkg.sv
// Shared definitions for the message byte sequencer.
// State encoding, ASCII line terminators and the message length limit.
package msg_pkg;

   localparam int MAX_MSG_LEN = 13;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SEND = 3'd2,
      CR   = 3'd3,
      LF   = 3'd4,
      DONE = 3'd5
   } state_e;

endpackage

// File: rtl/msg_byte_sequencer.sv
// Steps the byte mux select and hands each byte to the UART over valid/ready.
// Define MSG_SEQ_CRLF_EN to append CR and LF after the last mux byte.
module msg_byte_sequencer
   import msg_pkg::*;
#(
   parameter int MSG_LEN = MAX_MSG_LEN
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [3:0] sel,
   input  logic [7:0] byte_in,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0] LAST_SEL = 4'(MSG_LEN - 1);

   state_e     state_q, state_d;
   logic [3:0] sel_q, sel_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       xfer;

   assign xfer = valid_q & tx_ready;

   // Next-state, select and holding-register logic.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      data_d  = data_q;
      valid_d = valid_q;
      unique case (state_q)
         IDLE: begin
            sel_d = 4'd0;
            if (start) state_d = LOAD;
         end
         LOAD: begin
            data_d  = byte_in;
            valid_d = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (xfer) begin
               valid_d = 1'b0;
               if (sel_q == LAST_SEL) begin
`ifdef MSG_SEQ_CRLF_EN
                  data_d  = CHAR_CR;
                  valid_d = 1'b1;
                  state_d = CR;
`else
                  state_d = DONE;
`endif
               end else begin
                  sel_d   = sel_q + 4'd1;
                  state_d = LOAD;
               end
            end
         end
`ifdef MSG_SEQ_CRLF_EN
         CR: begin
            if (xfer) begin
               data_d  = CHAR_LF;
               state_d = LF;
            end
         end
         LF: begin
            if (xfer) begin
               valid_d = 1'b0;
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            sel_d   = 4'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= 4'd0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sel      = sel_q;
   assign tx_data  = data_q;
   assign tx_valid = valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
